cluster_count_monitor: RTL and testbench

Windowed statistics collector directly downstream of the cluster counter. It consumes the per-BX cluster count and overflow flag and accumulates them over a programmable number of valid samples. Per window it produces the sum, the maximum and the number of overflow samples. Each completed window is published as a snapshot that slow control collects through a valid/ack handshake.

---
 rtl/cluster_count_monitor.sv | 123 ++++++++++++
 tb/tb_cluster_count_monitor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_count_monitor.sv
// Windowed sum/max/overflow statistics over len valid samples; snapshot registered 1 edge after the final sample.
// No backpressure on samples: a window completing while the previous snapshot is unacknowledged is dropped and flagged on lost_o.
module cluster_count_monitor #(
   parameter int WINDOW_W = 16,
   parameter int SUM_W    = 32,
   parameter int OVF_W    = 16
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [10:0]         cnt_i,
   input  logic                overflow_i,
   input  logic                valid_i,
   input  logic                enable_i,
   input  logic [WINDOW_W-1:0] window_len_i,
   input  logic                snap_ack_i,
   input  logic                lost_clr_i,
   output logic                snap_valid_o,
   output logic [SUM_W-1:0]    snap_sum_o,
   output logic [10:0]         snap_max_o,
   output logic [OVF_W-1:0]    snap_ovf_o,
   output logic [WINDOW_W-1:0] snap_len_o,
   output logic                busy_o,
   output logic                lost_o
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state_q, state_d;
   logic [WINDOW_W-1:0] len_q, samples_q;
   logic [SUM_W-1:0]    sum_q, sum_nxt;
   logic [SUM_W:0]      sum_ext;
   logic [10:0]         max_q, max_nxt;
   logic [OVF_W-1:0]    ovf_q, ovf_nxt;
   logic                start, sample, complete, abort_win, publish, drop;

   always_comb begin
      state_d   = state_q;
      start     = 1'b0;
      sample    = 1'b0;
      complete  = 1'b0;
      abort_win = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable_i && window_len_i != '0) begin
               start   = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            sample   = valid_i;
            complete = valid_i && (samples_q + WINDOW_W'(1) == len_q);
            if (complete) begin
               state_d = (enable_i && window_len_i != '0) ? RUN : IDLE;
            end else if (!enable_i) begin
               abort_win = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Totals including the current sample; these are what a completing window publishes.
      sum_ext = {1'b0, sum_q} + (SUM_W+1)'(cnt_i);
      sum_nxt = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      max_nxt = (cnt_i > max_q) ? cnt_i : max_q;
      ovf_nxt = (overflow_i && ovf_q != '1) ? ovf_q + OVF_W'(1) : ovf_q;

      publish = complete && (!snap_valid_o || snap_ack_i);
      drop    = complete && snap_valid_o && !snap_ack_i;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   assign busy_o = (state_q == RUN);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         len_q        <= '0;
         samples_q    <= '0;
         sum_q        <= '0;
         max_q        <= '0;
         ovf_q        <= '0;
         snap_valid_o <= 1'b0;
         snap_sum_o   <= '0;
         snap_max_o   <= '0;
         snap_ovf_o   <= '0;
         snap_len_o   <= '0;
         lost_o       <= 1'b0;
      end else begin
         if (start || complete) len_q <= window_len_i;

         if (start || complete || abort_win) begin
            samples_q <= '0;
            sum_q     <= '0;
            max_q     <= '0;
            ovf_q     <= '0;
         end else if (sample) begin
            samples_q <= samples_q + WINDOW_W'(1);
            sum_q     <= sum_nxt;
            max_q     <= max_nxt;
            ovf_q     <= ovf_nxt;
         end

         if (publish) begin
            snap_valid_o <= 1'b1;
            snap_sum_o   <= sum_nxt;
            snap_max_o   <= max_nxt;
            snap_ovf_o   <= ovf_nxt;
            snap_len_o   <= len_q;
         end else if (snap_ack_i && snap_valid_o) begin
            snap_valid_o <= 1'b0;
         end

         // A drop in the same cycle as a clear must still be reported.
         if (drop)            lost_o <= 1'b1;
         else if (lost_clr_i) lost_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cluster_count_monitor.sv
// Bench for cluster_count_monitor: directed scenarios plus random traffic against a queue-based window model.
module tb_cluster_count_monitor;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [10:0] cnt_i = '0;
   logic        overflow_i = 1'b0, valid_i = 1'b0, enable_i = 1'b0;
   logic        snap_ack_i = 1'b0, lost_clr_i = 1'b0;
   logic [15:0] window_len_i = '0;

   logic        snap_valid_o, busy_o, lost_o;
   logic [31:0] snap_sum_o;
   logic [10:0] snap_max_o;
   logic [15:0] snap_ovf_o, snap_len_o;

   logic        snap_valid_s, busy_s, lost_s;
   logic [11:0] snap_sum_s;
   logic [10:0] snap_max_s;
   logic [1:0]  snap_ovf_s;
   logic [15:0] snap_len_s;

   cluster_count_monitor dut (
      .clock(clock), .reset_n(reset_n), .cnt_i(cnt_i), .overflow_i(overflow_i),
      .valid_i(valid_i), .enable_i(enable_i), .window_len_i(window_len_i),
      .snap_ack_i(snap_ack_i), .lost_clr_i(lost_clr_i), .snap_valid_o(snap_valid_o),
      .snap_sum_o(snap_sum_o), .snap_max_o(snap_max_o), .snap_ovf_o(snap_ovf_o),
      .snap_len_o(snap_len_o), .busy_o(busy_o), .lost_o(lost_o));

   cluster_count_monitor #(.WINDOW_W(16), .SUM_W(12), .OVF_W(2)) dut_small (
      .clock(clock), .reset_n(reset_n), .cnt_i(cnt_i), .overflow_i(overflow_i),
      .valid_i(valid_i), .enable_i(enable_i), .window_len_i(window_len_i),
      .snap_ack_i(snap_ack_i), .lost_clr_i(lost_clr_i), .snap_valid_o(snap_valid_s),
      .snap_sum_o(snap_sum_s), .snap_max_o(snap_max_s), .snap_ovf_o(snap_ovf_s),
      .snap_len_o(snap_len_s), .busy_o(busy_s), .lost_o(lost_s));

   initial forever #5 clock = ~clock;

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: the open window is a plain list of samples; totals are computed when it closes.
   bit     m_run = 0;
   int     m_len = 0;
   int     qc[$];
   int     qo[$];
   bit     e_vld = 0, e_lost = 0;
   longint e_sum = 0, e_sum_s = 0;
   int     e_max = 0, e_ovf = 0, e_ovf_s = 0, e_len = 0;

   task automatic model_step();
      bit old_vld, done, dropped;
      longint s;
      int mx, ov;
      old_vld = e_vld;
      done = 0;
      dropped = 0;
      if (!m_run) begin
         if (enable_i && window_len_i != 0) begin
            m_run = 1;
            m_len = window_len_i;
            qc.delete();
            qo.delete();
         end
      end else begin
         if (valid_i) begin
            qc.push_back(int'(cnt_i));
            qo.push_back(int'(overflow_i));
         end
         if (valid_i && qc.size() == m_len) begin
            done = 1;
            s = 0; mx = 0; ov = 0;
            foreach (qc[i]) begin
               s += qc[i];
               if (qc[i] > mx) mx = qc[i];
               ov += qo[i];
            end
            if (!old_vld || snap_ack_i) begin
               e_vld   = 1;
               e_sum   = (s > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : s;
               e_sum_s = (s > 4095) ? 4095 : s;
               e_max   = mx;
               e_ovf   = (ov > 65535) ? 65535 : ov;
               e_ovf_s = (ov > 3) ? 3 : ov;
               e_len   = m_len;
            end else begin
               dropped = 1;
            end
            qc.delete();
            qo.delete();
            m_len = window_len_i;
            m_run = enable_i && window_len_i != 0;
         end else if (!enable_i) begin
            m_run = 0;
            qc.delete();
            qo.delete();
         end
      end
      if (!done && old_vld && snap_ack_i) e_vld = 0;
      if (dropped) e_lost = 1;
      else if (lost_clr_i) e_lost = 0;
   endtask

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_run = 0; m_len = 0; qc.delete(); qo.delete();
         e_vld = 0; e_lost = 0; e_sum = 0; e_sum_s = 0;
         e_max = 0; e_ovf = 0; e_ovf_s = 0; e_len = 0;
      end else begin
         model_step();
      end
   end

   always @(negedge clock) begin
      check("snap_valid", snap_valid_o, e_vld);
      check("snap_sum", snap_sum_o, e_sum);
      check("snap_max", snap_max_o, e_max);
      check("snap_ovf", snap_ovf_o, e_ovf);
      check("snap_len", snap_len_o, e_len);
      check("busy", busy_o, m_run);
      check("lost", lost_o, e_lost);
      check("small_valid", snap_valid_s, e_vld);
      check("small_sum", snap_sum_s, e_sum_s);
      check("small_ovf", snap_ovf_s, e_ovf_s);
   end

   task automatic smp(input bit v, input int c, input bit o);
      valid_i = v;
      cnt_i = 11'(c);
      overflow_i = o;
      @(negedge clock);
   endtask

   task automatic ack_and_stop();
      enable_i = 0;
      snap_ack_i = 1;
      smp(0, 0, 0);
      snap_ack_i = 0;
   endtask

   initial begin
      repeat (3) @(negedge clock);
      reset_n = 1;
      repeat (3) @(negedge clock);
      check("rst_vld", snap_valid_o, 0);
      check("rst_busy", busy_o, 0);

      // Basic window; the valid sample on the entry cycle must be ignored.
      window_len_i = 4; enable_i = 1;
      smp(1, 100, 1);
      check("entry_busy", busy_o, 1);
      smp(1, 3, 0); smp(0, 50, 1); smp(1, 7, 0); smp(1, 2, 0); smp(1, 9, 1);
      check("basic_vld", snap_valid_o, 1);
      check("basic_sum", snap_sum_o, 21);
      check("basic_max", snap_max_o, 9);
      check("basic_ovf", snap_ovf_o, 1);
      check("basic_len", snap_len_o, 4);
      ack_and_stop();
      check("abort_busy0", busy_o, 0);
      check("ack_clears", snap_valid_o, 0);

      // Back-to-back windows, consumer acks whatever it sees.
      window_len_i = 2; enable_i = 1;
      smp(1, 5, 0);
      for (int i = 0; i < 8; i++) begin
         snap_ack_i = snap_valid_o;
         smp(1, 5, 0);
         if (snap_valid_o) check("b2b_sum", snap_sum_o, 10);
      end
      window_len_i = 1;
      for (int i = 0; i < 6; i++) begin
         snap_ack_i = snap_valid_o;
         smp(1, 5, 0);
      end
      snap_ack_i = 0;
      check("coincident_vld", snap_valid_o, 1);
      check("b2b_lost", lost_o, 0);
      check("len1_sum", snap_sum_o, 5);
      check("len1_len", snap_len_o, 1);

      // Drop when nobody acks.
      ack_and_stop();
      window_len_i = 1; enable_i = 1;
      smp(0, 0, 0);
      smp(1, 1, 0); smp(1, 2, 0); smp(1, 3, 0);
      check("drop_sum", snap_sum_o, 1);
      check("drop_lost", lost_o, 1);
      lost_clr_i = 1; smp(0, 0, 0); lost_clr_i = 0;
      check("lost_clr", lost_o, 0);
      lost_clr_i = 1; smp(1, 4, 0); lost_clr_i = 0;
      check("drop_beats_clr", lost_o, 1);
      check("drop_keeps_old", snap_sum_o, 1);

      // Asynchronous reset in RUN with a pending snapshot.
      #2 reset_n = 0; enable_i = 0;
      #1;
      check("arst_vld", snap_valid_o, 0);
      check("arst_sum", snap_sum_o, 0);
      check("arst_max", snap_max_o, 0);
      check("arst_ovf", snap_ovf_o, 0);
      check("arst_len", snap_len_o, 0);
      check("arst_busy", busy_o, 0);
      check("arst_lost", lost_o, 0);
      @(negedge clock); @(negedge clock);
      reset_n = 1;
      repeat (3) smp(1, 7, 1);
      check("post_rst_busy", busy_o, 0);

      // Abort after 5 of 8 samples, then a fresh window.
      window_len_i = 8; enable_i = 1;
      smp(0, 0, 0);
      repeat (5) smp(1, 10, 1);
      enable_i = 0;
      smp(0, 0, 0);
      check("abort_busy", busy_o, 0);
      check("abort_vld", snap_valid_o, 0);
      enable_i = 1;
      smp(0, 0, 0);
      repeat (8) smp(1, 1, 0);
      check("fresh_vld", snap_valid_o, 1);
      check("fresh_sum", snap_sum_o, 8);
      check("fresh_ovf", snap_ovf_o, 0);

      // Saturation on the narrow instance.
      ack_and_stop();
      window_len_i = 5; enable_i = 1;
      smp(0, 0, 0);
      repeat (5) smp(1, 1536, 1);
      check("sat_sum_small", snap_sum_s, 4095);
      check("sat_ovf_small", snap_ovf_s, 3);
      check("sat_max_small", snap_max_s, 1536);
      check("wide_sum", snap_sum_o, 7680);
      check("wide_ovf", snap_ovf_o, 5);

      // Random traffic.
      ack_and_stop();
      for (int i = 0; i < 3000; i++) begin
         enable_i     = ($urandom_range(0, 19) != 0);
         window_len_i = 16'($urandom_range(0, 6));
         snap_ack_i   = ($urandom_range(0, 2) == 0);
         lost_clr_i   = ($urandom_range(0, 24) == 0);
         smp($urandom_range(0, 3) != 0, int'($urandom_range(0, 1536)), $urandom_range(0, 3) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
